// File: rtl/fp_normalize_round_if.sv
// Handshake bundle between the dot-product adder, the normalize/round/pack stage
// and the result register file.
interface fp_normalize_round_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_exp;
    logic [50:0] in_sig;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_fp;
    logic        out_zero;
    logic        out_ovf;
    logic        out_unf;

    modport master (
        output in_valid, in_exp, in_sig, out_ready,
        input  in_ready, out_valid, out_fp, out_zero, out_ovf, out_unf
    );

    modport slave (
        input  in_valid, in_exp, in_sig, out_ready,
        output in_ready, out_valid, out_fp, out_zero, out_ovf, out_unf
    );
endinterface

// File: rtl/fp_normalize_round.sv
// Three-stage normalize/round/pack from the adder's 51-bit two's-complement sum
// to FP32 (no denormals). The whole pipeline freezes while the output is stalled.
module fp_normalize_round (
    input  logic                  clk,
    input  logic                  rst,
    fp_normalize_round_if.slave   bus
);

    logic               vld_p0, vld_p1, vld_p2;
    logic               stall, adv;

    logic               sign_p0;
    logic        [50:0] mag_p0;
    logic        [7:0]  exp_p0;

    logic               sign_p1;
    logic               zero_p1;
    logic        [49:0] norm_p1;
    logic signed [9:0]  en_p1;

    logic        [34:0] res_p2;

    logic        [5:0]  lead;
    logic        [50:0] norm;
    logic signed [9:0]  en;

    // Result word is {fp[31:0], zero, ovf, unf}; m holds the bits below the implicit one.
    function automatic logic [34:0] round_pack(input logic s, input logic z,
                                               input logic [49:0] m,
                                               input logic signed [9:0] e);
        logic              inc;
        logic [23:0]       frac_r;
        logic signed [9:0] ef;
        inc    = m[26] & ((|m[25:0]) | m[27]);
        frac_r = {1'b0, m[49:27]} + {23'd0, inc};
        ef     = e + (frac_r[23] ? 10'sd1 : 10'sd0);
        if (z)
            return {32'h0000_0000, 3'b100};
        else if (ef >= 10'sd255)
            return {s, 8'hFF, 23'h0, 3'b010};
        else if (ef <= 10'sd0)
            return {s, 31'h0, 3'b001};
        else
            return {s, ef[7:0], frac_r[22:0], 3'b000};
    endfunction

    assign stall        = vld_p2 & ~bus.out_ready;
    assign adv          = ~stall;
    assign bus.in_ready = ~stall;

    // S1: sign/magnitude
    always_ff @(posedge clk) begin
        if (adv && bus.in_valid) begin
            sign_p0 <= bus.in_sig[50];
            mag_p0  <= bus.in_sig[50] ? -bus.in_sig : bus.in_sig;
            exp_p0  <= bus.in_exp;
        end
    end

    always_comb begin
        lead = '0;
        for (int i = 0; i < 51; i++)
            if (mag_p0[i]) lead = 6'(i);
        norm = mag_p0 << (6'd50 - lead);
        en   = $signed({2'b00, exp_p0}) + $signed({4'b0000, lead}) - 10'sd46;
    end

    // S2: normalize; bit 50 of the shifted magnitude is the implicit one and is dropped
    always_ff @(posedge clk) begin
        if (adv && vld_p0) begin
            sign_p1 <= sign_p0;
            zero_p1 <= (mag_p0 == '0);
            norm_p1 <= norm[49:0];
            en_p1   <= en;
        end
    end

    // S3: round/pack; output data only changes when out_valid is loaded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            res_p2 <= '0;
        end else if (adv) begin
            vld_p0 <= bus.in_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            if (vld_p1)
                res_p2 <= round_pack(sign_p1, zero_p1, norm_p1, en_p1);
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.out_fp    = res_p2[34:3];
    assign bus.out_zero  = res_p2[2];
    assign bus.out_ovf   = res_p2[1];
    assign bus.out_unf   = res_p2[0];

endmodule

// File: tb/tb_fp_normalize_round.sv
// Bench for fp_normalize_round: directed FP32 vectors, random traffic against a
// arithmetic reference model, backpressure, bubbles and asynchronous reset.
module tb_fp_normalize_round;

    logic clk;
    logic rst;
    int   passed = 0;
    int   total  = 0;
    logic [34:0] exp_q[$];

    fp_normalize_round_if ifc();

    fp_normalize_round dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: exact integer rounding of |sig| to 24 significant bits.
    function automatic logic [34:0] model(input logic [7:0] e, input logic [50:0] s);
        logic   sg;
        longint m, q, rem, half;
        int     p, ex, sh;
        sg = s[50];
        m  = sg ? ((longint'(1) <<< 51) - longint'(s)) : longint'(s);
        if (m == 0) return {32'h0, 3'b100};
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        ex = int'(e) + p - 46;
        if (p > 23) begin
            sh   = p - 23;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                ex++;
            end
        end else begin
            q = m << (23 - p);
        end
        if (ex >= 255) return {sg, 8'hFF, 23'h0, 3'b010};
        if (ex <= 0)   return {sg, 31'h0, 3'b001};
        return {sg, ex[7:0], q[22:0], 3'b000};
    endfunction

    function automatic logic [50:0] rand_sig();
        logic [63:0] r;
        logic [50:0] s;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 3))
            0: s = r[50:0];
            1: s = r[50:0] >> $urandom_range(50, 0);
            2: s = (51'd1 << $urandom_range(49, 24)) | (r[50:0] >> $urandom_range(50, 20));
            default: s = ($urandom_range(0, 7) == 0) ? 51'd0 : (51'd1 << $urandom_range(49, 0));
        endcase
        if ($urandom_range(0, 1) == 1) s = -s;
        return s;
    endfunction

    // One clock cycle: drive at the falling edge, sample 1ns later, return at next falling edge.
    task automatic cycle(input logic v, input logic [7:0] e, input logic [50:0] s,
                         input logic rdy, output logic acc, output logic ir,
                         output logic ov, output logic [34:0] obs);
        ifc.in_valid  = v;
        ifc.in_exp    = e;
        ifc.in_sig    = s;
        ifc.out_ready = rdy;
        #1;
        ir  = ifc.in_ready;
        acc = v & ifc.in_ready;
        ov  = ifc.out_valid;
        obs = {ifc.out_fp, ifc.out_zero, ifc.out_ovf, ifc.out_unf};
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.in_valid = 1'b0; ifc.in_exp = '0; ifc.in_sig = '0; ifc.out_ready = 1'b1;
        @(negedge clk);
        total++; if (ifc.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", ifc.out_valid); else passed++;
        total++; if (ifc.out_fp !== 32'h0) $display("FAIL reset_out_fp got %h want 00000000", ifc.out_fp); else passed++;
        total++; if ({ifc.out_zero, ifc.out_ovf, ifc.out_unf} !== 3'b000)
            $display("FAIL reset_flags got %b want 000", {ifc.out_zero, ifc.out_ovf, ifc.out_unf}); else passed++;
        total++; if (ifc.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", ifc.in_ready); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0]  d_exp[10];
        logic [50:0] d_sig[10];
        logic [34:0] d_res[10];
        logic acc, ir, ov;
        logic [34:0] obs;
        int idx = 0;
        d_exp[0] = 8'd127; d_sig[0] = 51'h0400000000000; d_res[0] = {32'h3F800000, 3'b000};
        d_exp[1] = 8'd127; d_sig[1] = 51'h7C00000000000; d_res[1] = {32'hBF800000, 3'b000};
        d_exp[2] = 8'd128; d_sig[2] = 51'h0600000000000; d_res[2] = {32'h40400000, 3'b000};
        d_exp[3] = 8'd127; d_sig[3] = 51'h0400000400000; d_res[3] = {32'h3F800000, 3'b000};
        d_exp[4] = 8'd127; d_sig[4] = 51'h0400000C00000; d_res[4] = {32'h3F800002, 3'b000};
        d_exp[5] = 8'd127; d_sig[5] = 51'h07FFFFFFFFFFF; d_res[5] = {32'h40000000, 3'b000};
        d_exp[6] = 8'd254; d_sig[6] = 51'h1000000000000; d_res[6] = {32'h7F800000, 3'b010};
        d_exp[7] = 8'd1;   d_sig[7] = 51'h0200000000000; d_res[7] = {32'h00000000, 3'b001};
        d_exp[8] = 8'd77;  d_sig[8] = 51'h0;             d_res[8] = {32'h00000000, 3'b100};
        d_exp[9] = 8'd254; d_sig[9] = 51'h7000000000000; d_res[9] = {32'hFF800000, 3'b010};
        for (int c = 0; c < 16; c++) begin
            if (c < 10) cycle(1'b1, d_exp[c], d_sig[c], 1'b1, acc, ir, ov, obs);
            else        cycle(1'b0, 8'h0, 51'h0, 1'b1, acc, ir, ov, obs);
            total++; if (ov !== (c >= 3 && c < 13))
                $display("FAIL latency_out_valid cycle %0d got %b want %b", c, ov, (c >= 3 && c < 13)); else passed++;
            if (ov && idx < 10) begin
                total++; if (obs !== d_res[idx])
                    $display("FAIL directed_%0d got %h/%b want %h/%b", idx, obs[34:3], obs[2:0], d_res[idx][34:3], d_res[idx][2:0]);
                else passed++;
                idx++;
            end
        end
        total++; if (idx !== 10) $display("FAIL directed_count got %0d want 10", idx); else passed++;
    endtask

    task automatic test_random();
        logic acc, ir, ov, rdy, v, prev_stall;
        logic [7:0]  e;
        logic [50:0] s;
        logic [34:0] obs, prev_obs, want;
        prev_stall = 1'b0;
        prev_obs   = '0;
        for (int c = 0; c < 306; c++) begin
            v   = (c < 300) && ($urandom_range(0, 3) != 0);
            rdy = (c >= 300) || ($urandom_range(0, 3) != 0);
            e   = 8'($urandom_range(0, 255));
            s   = rand_sig();
            cycle(v, e, s, rdy, acc, ir, ov, obs);
            if (acc) exp_q.push_back(model(e, s));
            if (prev_stall) begin
                total++; if (!ov || obs !== prev_obs)
                    $display("FAIL random_stall_hold cycle %0d got %b/%h want 1/%h", c, ov, obs, prev_obs); else passed++;
            end
            if (ov && rdy) begin
                if (exp_q.size() == 0) begin
                    total++; $display("FAIL random_extra cycle %0d got %h want none", c, obs);
                end else begin
                    want = exp_q.pop_front();
                    total++; if (obs !== want)
                        $display("FAIL random_result cycle %0d got %h/%b want %h/%b", c, obs[34:3], obs[2:0], want[34:3], want[2:0]);
                    else passed++;
                end
            end
            prev_stall = ov & ~rdy;
            prev_obs   = obs;
        end
        total++; if (exp_q.size() != 0) $display("FAIL random_lost got %0d pending want 0", exp_q.size()); else passed++;
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic acc, ir, ov, rdy;
        logic [34:0] obs, held, want;
        logic [7:0]  e;
        logic [50:0] s;
        int sent = 0, got = 0;
        held = '0;
        e = 8'($urandom_range(1, 254));
        s = rand_sig();
        for (int c = 0; c < 40 && got < 10; c++) begin
            rdy = !(c >= 4 && c <= 7);
            cycle(sent < 10, e, s, rdy, acc, ir, ov, obs);
            if (c < 13) begin
                total++; if (ir !== rdy)
                    $display("FAIL bp_in_ready cycle %0d got %b want %b", c, ir, rdy); else passed++;
            end
            if (c == 4) held = obs;
            if (c >= 5 && c <= 8) begin
                total++; if (obs !== held) $display("FAIL bp_stable cycle %0d got %h want %h", c, obs, held); else passed++;
            end
            if (acc) begin
                exp_q.push_back(model(e, s));
                sent++;
                e = 8'($urandom_range(1, 254));
                s = rand_sig();
            end
            if (ov && rdy) begin
                got++;
                if (exp_q.size() == 0) begin
                    total++; $display("FAIL bp_extra cycle %0d got %h want none", c, obs);
                end else begin
                    want = exp_q.pop_front();
                    total++; if (obs !== want) $display("FAIL bp_order cycle %0d got %h want %h", c, obs, want); else passed++;
                end
            end
        end
        total++; if (got !== 10 || exp_q.size() != 0)
            $display("FAIL bp_count got %0d results want 10", got); else passed++;
        exp_q.delete();
    endtask

    task automatic test_bubbles();
        logic acc, ir, ov, v;
        logic [34:0] obs, want;
        logic [7:0]  e;
        logic [50:0] s;
        logic hist[20];
        for (int c = 0; c < 18; c++) begin
            v = (c < 12) && (c % 2 == 0);
            hist[c] = v;
            e = 8'($urandom_range(0, 255));
            s = rand_sig();
            cycle(v, e, s, 1'b1, acc, ir, ov, obs);
            if (acc) exp_q.push_back(model(e, s));
            total++; if (ov !== ((c >= 3) ? hist[c-3] : 1'b0))
                $display("FAIL bubble_out_valid cycle %0d got %b want %b", c, ov, (c >= 3) ? hist[c-3] : 1'b0); else passed++;
            if (ov) begin
                want = (exp_q.size() != 0) ? exp_q.pop_front() : 35'h0;
                total++; if (obs !== want) $display("FAIL bubble_result cycle %0d got %h want %h", c, obs, want); else passed++;
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_midstream();
        logic acc, ir, ov;
        logic [34:0] obs;
        for (int c = 0; c < 3; c++)
            cycle(1'b1, 8'd127, 51'h0400000000000 + 51'(c), 1'b1, acc, ir, ov, obs);
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        #1;
        total++; if (ifc.out_valid !== 1'b1) $display("FAIL midrst_inflight got %b want 1", ifc.out_valid); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (ifc.out_valid !== 1'b0) $display("FAIL midrst_async_valid got %b want 0", ifc.out_valid); else passed++;
        total++; if (ifc.out_fp !== 32'h0) $display("FAIL midrst_async_fp got %h want 00000000", ifc.out_fp); else passed++;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cycle(1'b0, 8'h0, 51'h0, 1'b1, acc, ir, ov, obs);
            total++; if (ov !== 1'b0) $display("FAIL midrst_stale cycle %0d got %b want 0", c, ov); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_bubbles();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fp_normalize_round.md
# fp_normalize_round

Pipelined normalize/round/pack stage directly downstream of the dot-product adder stage. It consumes the adder's 51-bit two's-complement sum and 8-bit aligned exponent and produces an IEEE-754 single-precision result with status flags. It is three register stages deep with valid/ready flow control, and it is the final stage before the result register file.

## Interface
Parameters: none. The format is fixed at FP32 with no denormal outputs.

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_exp/in_sig hold a valid sum
- in_ready  output  1  stage accepts input this cycle
- in_exp  input  8  biased exponent from the adder (bias 127)
- in_sig  input  51  two's-complement sum, 46 fraction bits; in_sig[50] is the sign
- out_valid  output  1  out_* hold a valid result
- out_ready  input  1  consumer accepts the result
- out_fp  output  32  packed FP32 {sign, exp[7:0], frac[22:0]}
- out_zero  output  1  result is an exact zero (sum was 0)
- out_ovf  output  1  overflow, result forced to ±inf
- out_unf  output  1  underflow, result flushed to signed zero

## Operation
- Value of the input: in_sig × 2^-46 × 2^(in_exp-127).
- **S1 (sign/magnitude)**
  - s = in_sig[50].
  - M = s ? -in_sig : in_sig, computed as a 51-bit unsigned value.
  - The register holds {s, M, in_exp}.
- **S2 (normalize)**
  - p = position of the leading one of M (0..50).
  - Left-shift M so the leading one sits at bit 50.
  - e_n = in_exp + p − 46, computed as a 10-bit signed value.
  - The register holds {s, zero=(M==0), shifted M, e_n}.
- **S3 (round/pack)**
  - frac = shifted bits [49:27]; guard = bit 26; sticky = OR of bits [25:0].
  - Round to nearest, ties to even: increment when guard & (sticky | frac[0]).
  - If the increment carries out of frac: frac = 0 and e_n + 1.
  - If p < 24 no bits are lost, so there is no rounding.
- **Classification** (first match wins)
  - zero: out_fp = 32'h0000_0000 (the sign is forced to 0); out_zero = 1.
  - final e ≥ 255: out_fp = {s, 8'hFF, 23'h0}; out_ovf = 1.
  - final e ≤ 0: out_fp = {s, 31'h0}; out_unf = 1.
  - otherwise: out_fp = {s, e[7:0], frac}.
- At most one flag is set per result.

## Timing
- **Reset**
  - All stage valid bits, out_valid, out_fp and all flags go to 0 asynchronously.
  - in_ready = 1 while no stall is possible.
  - In-flight data is dropped. The first acceptance is on the first clk edge after rst deasserts.
- **Latency**: an input accepted at edge k gives out_valid=1 after edge k+3 when there are no stalls.
- **Throughput**: one result per cycle.
- **Handshake**
  - Transfer in: in_valid & in_ready at a rising edge.
  - Transfer out: out_valid & out_ready at a rising edge.
- **Stall** = out_valid & ~out_ready.
  - in_ready = ~stall, decoded combinationally from registered out_valid and the out_ready input.
  - While stalled, S1, S2 and S3 all hold their contents, and out_* are stable.
  - Bubbles are not compressed: the whole pipeline freezes.
- A stage whose valid bit is 0 advances a bubble. Data registers may then load don't-care values, but out_fp and the flags must only change when out_valid is loaded.
- When out_ready=1 and a new input arrives in the same cycle, both transfers happen.
- Values of in_* are ignored when in_valid=0 or in_ready=0.

## Test plan
- **Unity and sign:** in_exp=127 with in_sig=51'h0400000000000 gives out_fp=3F800000. in_sig=51'h7C00000000000 (−1.0) gives BF800000. Both have all flags 0 and out_valid 3 cycles after acceptance.
- **Normalize and round:**
  - in_exp=128, in_sig=3·2^45 gives 40400000.
  - in_exp=127, in_sig=2^46+2^22 (tie, even) gives 3F800000.
  - in_sig=2^46+2^23+2^22 (tie, odd) gives 3F800002.
  - in_sig=2^47−1 gives 40000000 (the carry-out bumps the exponent).
- **Exceptions:**
  - in_exp=254 with in_sig=2^48 gives 7F800000 and out_ovf=1.
  - in_exp=1 with in_sig=2^45 gives 00000000 and out_unf=1.
  - in_sig=0 gives 00000000 and out_zero=1.
- **Backpressure:** stream 10 back-to-back inputs and hold out_ready=0 for cycles 4–7. in_ready must drop in the same cycles, out_fp must stay stable, and all 10 results must appear in order with none lost or duplicated.
- **Bubbles:** alternate in_valid 1/0. out_valid must follow the same pattern delayed by 3 cycles.
- **Reset mid-stream:** with 3 results in flight, pulse rst asynchronously between edges. out_valid must go 0 immediately, and no stale result may appear afterwards.
